// File: rtl/processor_gen2.sv
// processor_gen2: multi-cycle 8-register processor, T0..T5 FSM.
// Optional PROCESSOR_GEN2_MEM_WAIT_EN: stall fetch/load on Ready.
module processor_gen2 #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] DIN,
    input  logic             Ready,
    output logic [WIDTH-1:0] ADDR,
    output logic [WIDTH-1:0] DOUT,
    output logic             Write,
    output logic             Done
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [WIDTH-1:0] a_q, a_d, g_q, g_d, ir_q, ir_d;
    logic [WIDTH-1:0] addr_q, addr_d, dout_q, dout_d;
    logic             z_q, z_d, write_q, write_d;
    logic [2:0]       op, rx, ry;
    logic [WIDTH-1:0] alu;
    logic             mem_ok;
    logic             unused_ready;
    logic             is_alu;

    assign op = ir_q[WIDTH-1 -: 3];
    assign rx = ir_q[WIDTH-4 -: 3];
    assign ry = ir_q[WIDTH-7 -: 3];
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    assign unused_ready = Ready;

`ifdef PROCESSOR_GEN2_MEM_WAIT_EN
    assign mem_ok = Ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign ADDR  = addr_q;
    assign DOUT  = dout_q;
    assign Write = write_q;

    // ALU result for add/sub/and, consumed in T4
    always_comb begin
        alu = a_q & regs_q[ry];
        unique case (op)
            OP_ADD:  alu = a_q + regs_q[ry];
            OP_SUB:  alu = a_q - regs_q[ry];
            default: alu = a_q & regs_q[ry];
        endcase
    end

    // Done marks the final cycle of each instruction
    always_comb begin
        Done = 1'b0;
        unique case (state_q)
            T3:      Done = (op == OP_MV) || (op == OP_MVNZ);
            T4:      Done = (op == OP_ST);
            T5:      Done = (op == OP_MVI || op == OP_LD) ? mem_ok : 1'b1;
            default: Done = 1'b0;
        endcase
    end

    // Per-state datapath updates and next-state selection
    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        a_d     = a_q;
        g_d     = g_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        z_d     = z_q;
        write_d = 1'b0;
        unique case (state_q)
            T0: begin
                addr_d  = regs_q[7];
                state_d = Run ? T1 : T0;
            end
            T1: begin
                regs_d[7] = regs_q[7] + WIDTH'(1);
                state_d   = T2;
            end
            T2: begin
                if (mem_ok) begin
                    ir_d    = DIN;
                    state_d = T3;
                end
            end
            T3: begin
                unique case (op)
                    OP_MV:   regs_d[rx] = regs_q[ry];
                    OP_MVNZ: if (!z_q) regs_d[rx] = regs_q[ry];
                    OP_MVI: begin
                        addr_d    = regs_q[7];
                        regs_d[7] = regs_q[7] + WIDTH'(1);
                    end
                    OP_ADD:  a_d = regs_q[rx];
                    OP_SUB:  a_d = regs_q[rx];
                    OP_AND:  a_d = regs_q[rx];
                    OP_LD:   addr_d = regs_q[ry];
                    OP_ST:   addr_d = regs_q[ry];
                endcase
                state_d = Done ? T0 : T4;
            end
            T4: begin
                if (is_alu) begin
                    g_d = alu;
                    z_d = (alu == '0);
                end
                if (op == OP_ST) begin
                    dout_d  = regs_q[rx];
                    write_d = 1'b1;
                end
                state_d = Done ? T0 : T5;
            end
            T5: begin
                if (op == OP_MVI || op == OP_LD) begin
                    if (mem_ok) regs_d[rx] = DIN;
                end else begin
                    regs_d[rx] = g_q;
                end
                state_d = Done ? T0 : T5;
            end
            default: state_d = T0;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            a_q     <= '0;
            g_q     <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            z_q     <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
            a_q     <= a_d;
            g_q     <= g_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            z_q     <= z_d;
            write_q <= write_d;
        end
    end

endmodule

// File: doc/processor_gen2.md
PROCESSOR_GEN2 -- requirements
Module: processor_gen2

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data, address and instruction word width; legal range 9..32.
REQ-002 Clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  reset is synchronous and active-high.
REQ-004 Run  input  1  start-of-instruction permission, sampled only in state T0.
REQ-005 DIN  input  WIDTH  instruction or data returned by the addressed memory/IO device.
REQ-006 Ready  input  1  device data-valid strobe for DIN; used only when PROCESSOR_GEN2_MEM_WAIT_EN is defined.
REQ-007 ADDR  output  WIDTH  registered address to the memory/IO device.
REQ-008 DOUT  output  WIDTH  registered store data.
REQ-009 Write  output  1  registered; 1 means the device SHALL capture DOUT at ADDR.
REQ-010 Done  output  1  combinational; high in the last cycle of every instruction.

Function
REQ-011 Instruction fields SHALL be: opcode = IR[WIDTH-1:WIDTH-3], X = IR[WIDTH-4:WIDTH-6], Y = IR[WIDTH-7:WIDTH-9]; remaining low bits are ignored.
REQ-012 Opcodes SHALL be: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 and.
REQ-013 Register file SHALL hold R0..R6 as general-purpose registers and R7 as the PC, plus internal A, G, IR and Z (zero flag) registers, all WIDTH bits except Z (1 bit).
REQ-014 FSM states SHALL be T0..T5; Done in any state returns the FSM to T0 next cycle; T5 always returns to T0.
REQ-015 T0: ADDR<=PC; if Run=1 go to T1, else stay in T0.
REQ-016 T1: PC<=PC+1. T2: IR<=DIN.
REQ-017 mv: T3 Rx<=Ry, Done. Total latency 4 cycles.
REQ-018 mvnz: T3 Rx<=Ry only if Z=0, Done regardless. Total latency 4 cycles.
REQ-019 mvi: T3 ADDR<=PC and PC<=PC+1; T4 wait; T5 Rx<=DIN, Done. Total latency 6 cycles.
REQ-020 add/sub/and: T3 A<=Rx; T4 G<=A op Ry; T5 Rx<=G, Done.
REQ-021 For add/sub/and, Z SHALL be loaded in T4 with (result==0); no other instruction alters Z.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; sub computes Rx-Ry in two's complement; carry and borrow are discarded.
REQ-023 ld: T3 ADDR<=Ry; T4 wait; T5 Rx<=DIN, Done.
REQ-024 st: T3 ADDR<=Ry; T4 DOUT<=Rx, Write<=1, Done. Write SHALL be high for exactly the one cycle after T4 and low in all other cycles.
REQ-025 A write to R7 SHALL load the PC; if an increment and a load of the PC occur in the same cycle, the load SHALL take priority.
REQ-026 PC and all address arithmetic SHALL wrap from 2^WIDTH-1 to 0.
REQ-027 Run deasserting after T0 SHALL NOT affect an instruction already in progress.

Reset
REQ-028 When Reset=1 at a rising edge, the FSM SHALL enter T0 and PC, R0..R6, A, G, IR, Z, ADDR, DOUT and Write SHALL be set to 0, aborting any instruction in progress, including a store whose Write has not yet been issued.
REQ-029 While the FSM is in T0 after reset, Done SHALL be 0.

Configuration
REQ-030 When macro PROCESSOR_GEN2_MEM_WAIT_EN is defined, the FSM SHALL hold in T2 (fetch), and in T5 for mvi and ld, until Ready=1, and SHALL perform the state's register load only in the cycle where Ready=1.
REQ-031 When PROCESSOR_GEN2_MEM_WAIT_EN is not defined, Ready SHALL be ignored and the latencies in REQ-017..REQ-024 are fixed.

Verification
REQ-032 Reset, then run mvi R1,#5 and mvi R2,#3 followed by add R1,R2: R1=8, Z=0, with 6 cycles from T0 to Done for the add.
REQ-033 With WIDTH=16, R1=0xFFFF and R2=1, add R1,R2: R1=0x0000, Z=1; a following mvnz R3,R1 leaves R3 unchanged.
REQ-034 st R4,R5 with R4=0x1234 and R5=0x0040: ADDR=0x0040, DOUT=0x1234, Write high for exactly one cycle, Done at T4.
REQ-035 PC=0xFFFF fetching mv R0,R1: PC wraps to 0x0000; mv R7,R2 with R2=0x0100 gives a next fetch address of 0x0100.
REQ-036 Reset asserted in T4 of st: no Write pulse; the next cycle is T0 with all registers 0.
REQ-037 With PROCESSOR_GEN2_MEM_WAIT_EN defined, Ready held low for 3 cycles during ld: the FSM stays in T5 for 3 extra cycles, then Rx<=DIN in the cycle Ready=1, with Done asserted.
